// File: rtl/sram_pkt_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sram_pkt_ctrl
//  Brief    : Packet-driven controller for a bank of SRAM macros. Decodes one
//             command packet per handshake into one-cycle per-block strobes on
//             the R/W and RO ports, collects read data after READ_LATENCY
//             edges and returns it over a valid/ready response channel.
//  Optional : define SRAM_PKT_CTRL_PERF_EN to add saturating wr_count and
//             rd_count performance counters.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_pkt_ctrl #(
  parameter int RAM_BLOCKS   = 4,
  parameter int BSEL_W       = 2,
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  localparam int MASK_W      = DATA_WIDTH / 8,
  localparam int PKT_W       = 2 + BSEL_W + MASK_W + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                           clk_in,
  input  logic                           reset_n,
  input  logic                           pkt_valid,
  output logic                           pkt_ready,
  input  logic [PKT_W-1:0]               packet,
  output logic [RAM_BLOCKS-1:0]          chip_select,
  output logic [RAM_BLOCKS-1:0]          write_en,
  output logic [RAM_BLOCKS*MASK_W-1:0]   write_mask,
  output logic [ADDR_WIDTH-1:0]          addr,
  output logic [DATA_WIDTH-1:0]          data,
  output logic [RAM_BLOCKS-1:0]          read_enable,
  output logic [ADDR_WIDTH-1:0]          read_addr,
  input  logic [RAM_BLOCKS*DATA_WIDTH-1:0] rw_read_data,
  input  logic [RAM_BLOCKS*DATA_WIDTH-1:0] read_data,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_data,
`ifdef SRAM_PKT_CTRL_PERF_EN
  output logic [15:0]                    wr_count,
  output logic [15:0]                    rd_count,
`endif
  output logic [7:0]                     err_count
);

  // Opcodes
  localparam logic [1:0] c_op_nop   = 2'b00;
  localparam logic [1:0] c_op_write = 2'b01;
  localparam logic [1:0] c_op_rd_rw = 2'b10;
  localparam logic [1:0] c_op_rd_ro = 2'b11;

  // FSM states
  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  // One extra bit so the limit fits even when RAM_BLOCKS == 2**BSEL_W
  localparam logic [BSEL_W:0] c_blk_lim = (BSEL_W + 1)'(RAM_BLOCKS);
  localparam logic [2:0]      c_lat     = 3'(READ_LATENCY);

  // Packet fields, MSB first
  logic [1:0]            w_pkt_op;
  logic [BSEL_W-1:0]     w_pkt_blk;
  logic [MASK_W-1:0]     w_pkt_mask;
  logic [ADDR_WIDTH-1:0] w_pkt_addr;
  logic [DATA_WIDTH-1:0] w_pkt_wdata;

  assign w_pkt_op    = packet[PKT_W-1 -: 2];
  assign w_pkt_blk   = packet[PKT_W-3 -: BSEL_W];
  assign w_pkt_mask  = packet[ADDR_WIDTH+DATA_WIDTH +: MASK_W];
  assign w_pkt_addr  = packet[DATA_WIDTH +: ADDR_WIDTH];
  assign w_pkt_wdata = packet[DATA_WIDTH-1:0];

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic                    r_pkt_ready;
  logic [1:0]              r_op;
  logic [BSEL_W-1:0]       r_blk;
  logic [2:0]              r_cnt;
  logic [RAM_BLOCKS-1:0]   r_cs;
  logic [RAM_BLOCKS-1:0]   r_we;
  logic [RAM_BLOCKS*MASK_W-1:0] r_wm;
  logic [RAM_BLOCKS-1:0]   r_re;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [ADDR_WIDTH-1:0]   r_raddr;
  logic                    r_resp_valid;
  logic [DATA_WIDTH-1:0]   r_resp_data;
  logic [7:0]              r_err_count;

  logic                    w_accept;
  logic                    w_blk_ok;
  logic                    w_issue;
  logic                    w_reject;
  logic [RAM_BLOCKS-1:0]   w_sel;
  logic [RAM_BLOCKS-1:0]   w_cs_nxt;
  logic [RAM_BLOCKS-1:0]   w_we_nxt;
  logic [RAM_BLOCKS*MASK_W-1:0] w_wm_nxt;
  logic [RAM_BLOCKS-1:0]   w_re_nxt;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [DATA_WIDTH-1:0]   w_data_nxt;
  logic [ADDR_WIDTH-1:0]   w_raddr_nxt;
  logic [DATA_WIDTH-1:0]   w_rd_slice;

  // Invalid block numbers are rejected before the opcode is considered
  assign w_accept = (r_state == c_st_idle) && r_pkt_ready && pkt_valid;
  assign w_blk_ok = ({1'b0, w_pkt_blk} < c_blk_lim);
  assign w_issue  = w_accept && w_blk_ok && (w_pkt_op != c_op_nop);
  assign w_reject = w_accept && !w_blk_ok;

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (w_issue) w_state_nxt = c_st_issue;
      c_st_issue: w_state_nxt = (r_op == c_op_write) ? c_st_idle : c_st_wait;
      c_st_wait:  if (r_cnt == 3'd1) w_state_nxt = c_st_resp;
      c_st_resp:  if (resp_ready) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Next values of the SRAM-side registers; strobes land in the ISSUE cycle
  always_comb begin
    w_sel       = '0;
    w_cs_nxt    = '0;
    w_we_nxt    = '0;
    w_wm_nxt    = '0;
    w_re_nxt    = '0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_raddr_nxt = r_raddr;
    for (int b = 0; b < RAM_BLOCKS; b++) begin
      w_sel[b] = (w_pkt_blk == BSEL_W'(b));
    end
    if (w_issue) begin
      case (w_pkt_op)
        c_op_write: begin
          w_cs_nxt   = w_sel;
          w_we_nxt   = w_sel;
          w_addr_nxt = w_pkt_addr;
          w_data_nxt = w_pkt_wdata;
          for (int b = 0; b < RAM_BLOCKS; b++) begin
            w_wm_nxt[b*MASK_W +: MASK_W] = w_sel[b] ? w_pkt_mask : '0;
          end
        end
        c_op_rd_rw: begin
          w_cs_nxt   = w_sel;
          w_addr_nxt = w_pkt_addr;
        end
        c_op_rd_ro: begin
          w_re_nxt    = w_sel;
          w_raddr_nxt = w_pkt_addr;
        end
        default: ;
      endcase
    end
  end

  // Read-data slice of the block being read, from the port that was strobed
  always_comb begin
    w_rd_slice = '0;
    for (int b = 0; b < RAM_BLOCKS; b++) begin
      if (r_blk == BSEL_W'(b)) begin
        w_rd_slice = (r_op == c_op_rd_ro) ? read_data[b*DATA_WIDTH +: DATA_WIDTH]
                                          : rw_read_data[b*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output registers, command latch, latency counter, response and error count
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_ready  <= 1'b0;
      r_op         <= c_op_nop;
      r_blk        <= '0;
      r_cnt        <= '0;
      r_cs         <= '0;
      r_we         <= '0;
      r_wm         <= '0;
      r_re         <= '0;
      r_addr       <= '0;
      r_data       <= '0;
      r_raddr      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_err_count  <= '0;
    end else begin
      r_pkt_ready <= (w_state_nxt == c_st_idle);
      r_cs        <= w_cs_nxt;
      r_we        <= w_we_nxt;
      r_wm        <= w_wm_nxt;
      r_re        <= w_re_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_raddr     <= w_raddr_nxt;
      if (w_issue) begin
        r_op  <= w_pkt_op;
        r_blk <= w_pkt_blk;
      end
      if (r_state == c_st_issue) begin
        r_cnt <= c_lat;
      end else if (r_state == c_st_wait) begin
        r_cnt <= r_cnt - 3'd1;
      end
      if ((r_state == c_st_wait) && (r_cnt == 3'd1)) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_rd_slice;
      end else if (r_resp_valid && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
      if (w_reject && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end
  end

`ifdef SRAM_PKT_CTRL_PERF_EN
  logic [15:0] r_wr_count;
  logic [15:0] r_rd_count;

  // Saturating per-operation counters, stepped once per ISSUE cycle
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else if (r_state == c_st_issue) begin
      if (r_op == c_op_write) begin
        if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
      end else begin
        if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
      end
    end
  end

  assign wr_count = r_wr_count;
  assign rd_count = r_rd_count;
`endif

  assign pkt_ready   = r_pkt_ready;
  assign chip_select = r_cs;
  assign write_en    = r_we;
  assign write_mask  = r_wm;
  assign addr        = r_addr;
  assign data        = r_data;
  assign read_enable = r_re;
  assign read_addr   = r_raddr;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign err_count   = r_err_count;

endmodule
`default_nettype wire
